// File: rtl/fft_pkg.sv
// Shared constants and types for the 64-point FFT output-stream consumers.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_DW    = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  typedef logic [2*FFT_DW:0] mag_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DRAIN    = 3'd2,
    REPORT   = 3'd3,
    WAIT_LOW = 3'd4
  } peak_state_t;

endpackage

// File: rtl/fft_peak_detector_mag_sq_pipe.sv
// Two-stage |X|^2 unit: stage 1 squares re and im, stage 2 sums them.
// A valid bit and an index sideband travel alongside the data.
module mag_sq_pipe #(
  parameter int DW = 16,
  parameter int IW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic [2*DW-1:0] i_data,
  input  logic [IW-1:0]   i_idx,
  output logic            o_valid,
  output logic [2*DW:0]   o_mag,
  output logic [IW-1:0]   o_idx
);

  logic signed [DW-1:0]   w_re;
  logic signed [DW-1:0]   w_im;
  logic signed [2*DW-1:0] r_re_sq;
  logic signed [2*DW-1:0] r_im_sq;
  logic                   r_v1;
  logic [IW-1:0]          r_idx1;
  logic                   r_v2;
  logic [2*DW:0]          r_mag;
  logic [IW-1:0]          r_idx2;

  assign w_re = i_data[2*DW-1:DW];
  assign w_im = i_data[DW-1:0];

  // Squares are non-negative, so the sum is formed as an unsigned 2*DW+1 value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_idx1  <= '0;
      r_idx2  <= '0;
      r_mag   <= '0;
    end else begin
      r_v1    <= i_valid & ~i_flush;
      r_re_sq <= w_re * w_re;
      r_im_sq <= w_im * w_im;
      r_idx1  <= i_idx;
      r_v2    <= r_v1 & ~i_flush;
      r_mag   <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
      r_idx2  <= r_idx1;
    end
  end

  assign o_valid = r_v2;
  assign o_mag   = r_mag;
  assign o_idx   = r_idx2;

endmodule

// File: rtl/fft_peak_detector.sv
// Tracks the largest-|X|^2 bin of each FFT output frame and reports it once per frame.
// Optional PEAK_THRESHOLD_EN adds a minimum-magnitude qualifier (threshold in, peak_found out).
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int MIN_BIN = 1,
  parameter int DW      = FFT_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic                   bin_valid,
  input  logic [2*DW-1:0]        data_in,
`ifdef PEAK_THRESHOLD_EN
  input  logic [2*DW:0]          threshold,
  output logic                   peak_found,
`endif
  output logic                   peak_valid,
  output logic [$clog2(N)-1:0]   peak_bin,
  output logic [2*DW:0]          peak_mag,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int LW = $clog2(N);
  localparam int MW = 2*DW + 1;

  peak_state_t   r_state;
  logic          r_done_d;
  logic [LW-1:0] r_bin_cnt;
  logic          r_drain;
  logic [MW-1:0] r_best_mag;
  logic [LW-1:0] r_best_bin;
  logic          r_peak_valid;
  logic [LW-1:0] r_peak_bin;
  logic [MW-1:0] r_peak_mag;
  logic          r_frame_err;
`ifdef PEAK_THRESHOLD_EN
  logic [MW-1:0] r_threshold;
  logic          r_peak_found;
`endif

  logic          w_start;
  logic          w_strobe;
  logic          w_pipe_valid;
  logic [MW-1:0] w_pipe_mag;
  logic [LW-1:0] w_pipe_idx;
  logic          w_in_band;
  logic          w_better;

  assign w_start   = (r_state == IDLE) && fft_done && !r_done_d;
  assign w_strobe  = (r_state == COLLECT) && fft_done && bin_valid;
  assign w_in_band = (w_pipe_idx >= LW'(MIN_BIN)) && (w_pipe_idx < LW'(N/2));
  assign w_better  = w_pipe_valid && w_in_band && (w_pipe_mag > r_best_mag);

  mag_sq_pipe #(.DW(DW), .IW(LW)) u_mag (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_start),
    .i_valid (w_strobe),
    .i_data  (data_in),
    .i_idx   (r_bin_cnt),
    .o_valid (w_pipe_valid),
    .o_mag   (w_pipe_mag),
    .o_idx   (w_pipe_idx)
  );

  // Frame FSM, running maximum and registered report outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_done_d     <= 1'b0;
      r_bin_cnt    <= '0;
      r_drain      <= 1'b0;
      r_best_mag   <= '0;
      r_best_bin   <= '0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_frame_err  <= 1'b0;
`ifdef PEAK_THRESHOLD_EN
      r_threshold  <= '0;
      r_peak_found <= 1'b0;
`endif
    end else begin
      r_done_d     <= fft_done;
      r_peak_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      // Strict compare in natural bin order keeps the lower index on ties.
      if (w_start) begin
        r_best_mag <= '0;
        r_best_bin <= LW'(MIN_BIN);
      end else if (w_better) begin
        r_best_mag <= w_pipe_mag;
        r_best_bin <= w_pipe_idx;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= COLLECT;
            r_bin_cnt <= '0;
`ifdef PEAK_THRESHOLD_EN
            r_threshold <= threshold;
`endif
          end
        end
        COLLECT: begin
          if (!fft_done) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end else if (bin_valid) begin
            r_bin_cnt <= r_bin_cnt + LW'(1);
            if (r_bin_cnt == LW'(N-1)) begin
              r_state <= DRAIN;
              r_drain <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= REPORT;
          end else begin
            r_drain <= 1'b1;
          end
        end
        REPORT: begin
          r_peak_valid <= 1'b1;
          r_state      <= WAIT_LOW;
`ifdef PEAK_THRESHOLD_EN
          if (r_best_mag >= r_threshold) begin
            r_peak_found <= 1'b1;
            r_peak_bin   <= r_best_bin;
            r_peak_mag   <= r_best_mag;
          end else begin
            r_peak_found <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
          end
`else
          r_peak_bin <= r_best_bin;
          r_peak_mag <= r_best_mag;
`endif
        end
        WAIT_LOW: begin
          if (!fft_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == COLLECT) || (r_state == DRAIN);
`ifdef PEAK_THRESHOLD_EN
  assign peak_found = r_peak_found;
`endif

endmodule

// File: tb/tb_fft_peak_detector.sv
// Randomized self-checking bench for fft_peak_detector against a frame-level reference model.
// Build with PEAK_THRESHOLD_EN defined to exercise the threshold qualifier.
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int N       = 64;
  localparam int MIN_BIN = 1;
  localparam int DW      = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fft_done = 1'b0;
  logic          bin_valid = 1'b0;
  logic [31:0]   data_in = '0;
  logic          peak_valid;
  logic [5:0]    peak_bin;
  logic [32:0]   peak_mag;
  logic          frame_err;
  logic          busy;
`ifdef PEAK_THRESHOLD_EN
  logic [32:0]   threshold = '0;
  logic          peak_found;
`endif

  int     checks = 0;
  int     failures = 0;
  int     fr_re [N];
  int     fr_im [N];
  longint last_mag = 0;
  int     last_bin = 0;

  fft_peak_detector #(.N(N), .MIN_BIN(MIN_BIN), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fft_done   (fft_done),
    .bin_valid  (bin_valid),
    .data_in    (data_in),
`ifdef PEAK_THRESHOLD_EN
    .threshold  (threshold),
    .peak_found (peak_found),
`endif
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void clear_frame();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference: maximum of re^2+im^2 over the searched band, first occurrence wins.
  function automatic void model(output int bin, output longint mag);
    longint m;
    bin = MIN_BIN;
    mag = 0;
    for (int i = MIN_BIN; i < N/2; i++) begin
      m = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
      if (m > mag) begin
        mag = m;
        bin = i;
      end
    end
  endfunction

  task automatic drive_bin(input int i);
    cplx_t c;
    c.re = 16'(fr_re[i]);
    c.im = 16'(fr_im[i]);
    bin_valid = 1'b1;
    data_in = c;
  endtask

  // stop_at < N aborts the frame early, either by dropping fft_done or by reset.
  task automatic run_frame(input bit gaps, input int stop_at, input bit use_reset, input bit extra);
    int     exp_bin;
    longint exp_mag;
    int     lat;
    int     seen;
    @(negedge clk);
    fft_done = 1'b1;
    bin_valid = 1'b1;
    data_in = 32'h8000_8000;
    @(negedge clk);
    chk("busy_collect", busy, 1);
    for (int i = 0; i < stop_at; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bin_valid = 1'b0;
        @(negedge clk);
      end
      drive_bin(i);
      @(negedge clk);
    end
    if (stop_at < N) begin
      bin_valid = 1'b0;
      fft_done = 1'b0;
      if (use_reset) begin
        reset = 1'b0;
        @(negedge clk);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        last_bin = 0;
        last_mag = 0;
      end else begin
        @(negedge clk);
        chk("frame_err_pulse", frame_err, 1);
        chk("busy_after_err", busy, 0);
      end
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (peak_valid || frame_err) seen++;
      end
      chk("quiet_after_abort", seen, 0);
      chk("hold_bin", peak_bin, last_bin);
      chk("hold_mag", peak_mag, last_mag);
      return;
    end
    if (extra) begin
      bin_valid = 1'b1;
      data_in = 32'h8000_8000;
    end else begin
      bin_valid = 1'b0;
    end
    model(exp_bin, exp_mag);
`ifdef PEAK_THRESHOLD_EN
    if (exp_mag < longint'(threshold)) begin
      exp_bin = 0;
      exp_mag = 0;
    end
`endif
    lat = 0;
    while (!peak_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    bin_valid = 1'b0;
    chk("peak_latency", lat, 3);
    chk("peak_bin", peak_bin, exp_bin);
    chk("peak_mag", peak_mag, exp_mag);
`ifdef PEAK_THRESHOLD_EN
    chk("peak_found", peak_found, (exp_mag == 0 && exp_mag < longint'(threshold)) ? 0 :
        ((exp_mag >= longint'(threshold)) ? 1 : 0));
`endif
    last_bin = exp_bin;
    last_mag = exp_mag;
    @(negedge clk);
    chk("pulse_width", peak_valid, 0);
    chk("busy_wait_low", busy, 0);
    fft_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_peak_valid", peak_valid, 0);
    chk("reset_peak_bin", peak_bin, 0);
    chk("reset_peak_mag", peak_mag, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);

    clear_frame();
    fr_re[5] = 1000;
    run_frame(1'b1, N, 1'b0, 1'b0);

    clear_frame();
    fr_re[0] = 32767; fr_im[0] = 32767;
    fr_re[40] = 30000;
    fr_re[7] = 100; fr_im[7] = -100;
    run_frame(1'b1, N, 1'b0, 1'b0);

    clear_frame();
    fr_re[9] = -300; fr_im[9] = 400;
    fr_re[12] = -300; fr_im[12] = 400;
    run_frame(1'b0, N, 1'b0, 1'b0);

    clear_frame();
    fr_re[3] = -32768; fr_im[3] = -32768;
    run_frame(1'b0, N, 1'b0, 1'b1);

    clear_frame();
    run_frame(1'b1, N, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        fr_re[i] = rnd16();
        fr_im[i] = rnd16();
      end
      run_frame(f[0], N, 1'b0, f[1]);
    end

    run_frame(1'b1, 20, 1'b0, 1'b0);
    run_frame(1'b0, 30, 1'b1, 1'b0);

    clear_frame();
    fr_re[17] = -1234; fr_im[17] = 77;
    fr_re[31] = 1234;
    run_frame(1'b1, N, 1'b0, 1'b0);

`ifdef PEAK_THRESHOLD_EN
    clear_frame();
    fr_re[5] = 1000;
    threshold = 33'd1_000_001;
    run_frame(1'b0, N, 1'b0, 1'b0);
    threshold = 33'd1_000_000;
    run_frame(1'b0, N, 1'b0, 1'b0);
    threshold = 33'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
